stencil_pipeline_ctrl: RTL

- Parametrised start/done sequencer for unrolled stencil pipelines: the generalised successor of the single-flag start/started controller.
- Walks a 2-D iteration domain (x inner, y outer) at a configurable initiation interval.
- Fans out per-stage enables delayed by per-stage latencies, with iteration coordinates and an at-iteration-0 flag for each stage.
- Supports a global stall and drains cleanly.
- Sits at the top of a generated pipeline; drives the start/enable inputs of buffer and op instances.

---
 rtl/stencil_pipeline_ctrl_pkg.sv | 51 +++++
 rtl/stencil_pipeline_ctrl_if.sv | 32 +++
 rtl/stencil_pipeline_ctrl_iter_delay_line.sv | 49 ++++
 rtl/stencil_pipeline_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/stencil_pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stencil_ctrl_pkg
//   Shared types and helpers for the stencil pipeline start/done sequencer.
//   - ctrl_state_t : sequencer FSM states
//   - iter_tag_t   : one delay-line entry {valid, at0, x, y}
//   - max_lat()    : largest per-stage latency in a packed latency vector
// -----------------------------------------------------------------------------
package stencil_ctrl_pkg;

    // Default coordinate width; iter_tag_t fields are sized from it.
    localparam int CNT_W = 16;

    // Widest packed latency vector max_lat() accepts.
    localparam int LAT_VEC_W = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic             valid;
        logic             at0;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } iter_tag_t;

    // Reduce a packed NUM_STAGES x LAT_W latency vector (stage 0 in the LSBs)
    // to its maximum field. Used at elaboration time to size the delay line.
    function automatic int max_lat(input int num_stages, input int lat_w,
                                   input logic [LAT_VEC_W-1:0] lat_vec);
        int m;
        int v;
        m = 0;
        for (int i = 0; i < num_stages; i++) begin
            v = 0;
            for (int b = 0; b < lat_w; b++) begin
                if (lat_vec[10'(i * lat_w + b)]) begin
                    v = v | (1 << b);
                end
            end
            if (v > m) begin
                m = v;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/stencil_pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// stencil_pipeline_ctrl_if
//   Control/status bundle of the stencil sequencer.
//   master : drives start, cfg_x_extent, cfg_y_extent, stall;
//            observes stage_en, stage_at_iter_0, stage_x, stage_y, busy, done
//   slave  : the sequencer side (directions reversed)
// -----------------------------------------------------------------------------
interface stencil_pipeline_ctrl_if #(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 16
) ();
    logic                        start;
    logic [CNT_W-1:0]            cfg_x_extent;
    logic [CNT_W-1:0]            cfg_y_extent;
    logic                        stall;
    logic [NUM_STAGES-1:0]       stage_en;
    logic [NUM_STAGES-1:0]       stage_at_iter_0;
    logic [NUM_STAGES*CNT_W-1:0] stage_x;
    logic [NUM_STAGES*CNT_W-1:0] stage_y;
    logic                        busy;
    logic                        done;

    modport master (
        output start, cfg_x_extent, cfg_y_extent, stall,
        input  stage_en, stage_at_iter_0, stage_x, stage_y, busy, done
    );

    modport slave (
        input  start, cfg_x_extent, cfg_y_extent, stall,
        output stage_en, stage_at_iter_0, stage_x, stage_y, busy, done
    );
endinterface

// File: rtl/stencil_pipeline_ctrl_iter_delay_line.sv
// -----------------------------------------------------------------------------
// iter_delay_line
//   Stallable shift register of iteration tags with one tap per stage.
//   clk, rst  : clock, asynchronous active-high reset
//   stall_i   : freezes every slot
//   tag_i     : tag issued by the root this cycle
//   taps_o[k] : tag issued STAGE_LAT[k] non-stalled cycles ago
//               (latency 0 taps the input combinationally)
// -----------------------------------------------------------------------------
module iter_delay_line
    import stencil_ctrl_pkg::*;
#(
    parameter int                          NUM_STAGES = 3,
    parameter int                          LAT_W      = 8,
    parameter logic [NUM_STAGES*LAT_W-1:0] STAGE_LAT  = {8'd4, 8'd2, 8'd0},
    parameter int                          DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    input  iter_tag_t                  tag_i,
    output iter_tag_t [NUM_STAGES-1:0] taps_o
);

    // chain[j] holds the tag issued j non-stalled cycles ago.
    iter_tag_t chain [DEPTH+1];

    assign chain[0] = tag_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        iter_tag_t slot_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_q <= '0;
            end else if (!stall_i) begin
                slot_q <= chain[gi];
            end
        end

        assign chain[gi+1] = slot_q;
    end

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_tap
        localparam int L = int'(STAGE_LAT[gi*LAT_W +: LAT_W]);
        assign taps_o[gi] = chain[L];
    end

endmodule

// File: rtl/stencil_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// stencil_pipeline_ctrl
//   Start/done sequencer for an unrolled stencil pipeline. Walks an
//   x (inner) by y (outer) domain at initiation interval II and fans out
//   per-stage enables delayed by STAGE_LAT[k], with coordinates and an
//   iteration-(0,0) flag.
//   clk     : clock
//   rst     : asynchronous active-high reset (aborts a run, no done)
//   ctrl_if : slave side of stencil_pipeline_ctrl_if
//             start/cfg_*_extent/stall in; stage_* / busy / done out
// -----------------------------------------------------------------------------
module stencil_pipeline_ctrl
    import stencil_ctrl_pkg::*;
#(
    parameter int                          NUM_STAGES = 3,
    parameter int                          CNT_W      = stencil_ctrl_pkg::CNT_W,
    parameter int                          II         = 1,
    parameter int                          LAT_W      = 8,
    parameter logic [NUM_STAGES*LAT_W-1:0] STAGE_LAT  = {8'd4, 8'd2, 8'd0}
) (
    input logic                    clk,
    input logic                    rst,
    stencil_pipeline_ctrl_if.slave ctrl_if
);

    localparam int MAX_LAT = max_lat(NUM_STAGES, LAT_W, LAT_VEC_W'(STAGE_LAT));
    localparam int II_W    = (II > 1) ? $clog2(II) : 1;

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [CNT_W-1:0] x_ext_q, x_ext_d;
    logic [CNT_W-1:0] y_ext_q, y_ext_d;
    logic [II_W-1:0]  ii_cnt_q, ii_cnt_d;
    logic [LAT_W-1:0] drain_cnt_q, drain_cnt_d;

    logic      issue;
    logic      x_last;
    logic      last_issue;
    iter_tag_t root_tag;
    iter_tag_t [NUM_STAGES-1:0] taps;

    // Wrap compares against extent-1, so an all-ones extent never overflows.
    assign x_last     = (x_q == x_ext_q - 1'b1);
    assign last_issue = x_last && (y_q == y_ext_q - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            x_ext_q     <= '0;
            y_ext_q     <= '0;
            ii_cnt_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x_ext_q     <= x_ext_d;
            y_ext_q     <= y_ext_d;
            ii_cnt_q    <= ii_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        x_ext_d     = x_ext_q;
        y_ext_d     = y_ext_q;
        ii_cnt_d    = ii_cnt_q;
        drain_cnt_d = drain_cnt_q;
        issue       = 1'b0;

        // Every transition waits for stall to drop, so a stall freezes the
        // sequencer in whatever state it is in.
        case (state_q)
            IDLE: begin
                if (ctrl_if.start && !ctrl_if.stall) begin
                    x_ext_d  = ctrl_if.cfg_x_extent;
                    y_ext_d  = ctrl_if.cfg_y_extent;
                    x_d      = '0;
                    y_d      = '0;
                    ii_cnt_d = '0;
                    if ((ctrl_if.cfg_x_extent == '0) || (ctrl_if.cfg_y_extent == '0)) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (!ctrl_if.stall) begin
                    ii_cnt_d = (ii_cnt_q == II_W'(II - 1)) ? '0 : ii_cnt_q + 1'b1;
                    if (ii_cnt_q == '0) begin
                        issue = 1'b1;
                        if (last_issue) begin
                            if (MAX_LAT == 0) begin
                                state_d = FIN;
                            end else begin
                                // DRAIN lasts MAX_LAT non-stalled cycles, so
                                // FIN lands right after the deepest stage fires.
                                state_d     = DRAIN;
                                drain_cnt_d = LAT_W'(MAX_LAT - 1);
                            end
                        end else if (x_last) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end

            DRAIN: begin
                if (!ctrl_if.stall) begin
                    if (drain_cnt_q == '0) begin
                        state_d = FIN;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                    end
                end
            end

            FIN: begin
                if (!ctrl_if.stall) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Idle slots still carry the live counters; only valid matters downstream.
    assign root_tag.valid = issue;
    assign root_tag.at0   = (x_q == '0) && (y_q == '0);
    assign root_tag.x     = x_q;
    assign root_tag.y     = y_q;

    iter_delay_line #(
        .NUM_STAGES (NUM_STAGES),
        .LAT_W      (LAT_W),
        .STAGE_LAT  (STAGE_LAT),
        .DEPTH      (MAX_LAT)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .stall_i (ctrl_if.stall),
        .tag_i   (root_tag),
        .taps_o  (taps)
    );

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        assign ctrl_if.stage_en[gi]                = taps[gi].valid & ~ctrl_if.stall;
        assign ctrl_if.stage_at_iter_0[gi]         = taps[gi].at0 & taps[gi].valid & ~ctrl_if.stall;
        assign ctrl_if.stage_x[gi*CNT_W +: CNT_W]  = taps[gi].x;
        assign ctrl_if.stage_y[gi*CNT_W +: CNT_W]  = taps[gi].y;
    end

    assign ctrl_if.busy = (state_q == RUN) || (state_q == DRAIN);
    assign ctrl_if.done = (state_q == FIN) && !ctrl_if.stall;

endmodule
